// File: rtl/adiabatic_pclk_seq.sv
// Four-phase trapezoidal power-clock sequencer with staggered start and graceful drain.
// Levels are a combinational decode of registered state; requests take effect on the next edge.
module adiabatic_pclk_seq #(
   parameter int STEPS = 4,
   parameter int CYC_W = 16,
   localparam int LW = $clog2(STEPS + 1),
   localparam int CW = $clog2(STEPS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   output logic              busy,
   output logic              done,
   output logic [4*LW-1:0]   lvl,
   output logic [3:0]        hold_vld,
   output logic [CYC_W-1:0]  cyc_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [1:0]       q, q_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [3:0]       armed, armed_nxt;
   logic [CYC_W-1:0] cyc_nxt;
   logic             done_nxt;
   logic             cnt_last;
   logic             draining;

   assign cnt_last = (cnt == CW'(STEPS - 1));
   // A stop seen in RUN already counts as draining on that edge, so no phase arms during the handover.
   assign draining = (state == S_DRAIN) || ((state == S_RUN) && stop);

   always_comb begin
      state_nxt = state;
      q_nxt     = q;
      cnt_nxt   = cnt;
      armed_nxt = armed;
      cyc_nxt   = cyc_cnt;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
               q_nxt     = 2'd0;
               cnt_nxt   = '0;
               armed_nxt = 4'b0001;
               cyc_nxt   = '0;
            end
         end
         S_RUN, S_DRAIN: begin
            if (cnt_last) begin
               cnt_nxt = '0;
               q_nxt   = q + 2'd1;
               if (q == 2'd3) begin
                  cyc_nxt = cyc_cnt + 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
            if (!draining) begin
               if (cnt_last) begin
                  armed_nxt[q_nxt] = 1'b1;
               end
            end else begin
               // Park a phase only as it enters its wait quarter, so every trapezoid completes.
               for (int k = 0; k < 4; k++) begin
                  if (2'(q_nxt - 2'(k)) == 2'd3) begin
                     armed_nxt[k] = 1'b0;
                  end
               end
               if (armed_nxt == 4'b0000) begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = S_DRAIN;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            armed_nxt = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         q       <= 2'd0;
         cnt     <= '0;
         armed   <= 4'b0000;
         cyc_cnt <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         q       <= q_nxt;
         cnt     <= cnt_nxt;
         armed   <= armed_nxt;
         cyc_cnt <= cyc_nxt;
         done    <= done_nxt;
      end
   end

   assign busy = (state != S_IDLE);

   for (genvar k = 0; k < 4; k++) begin : g_phase
      logic [1:0]    pk;
      logic [LW-1:0] lv;

      assign pk = q - 2'(k);

      always_comb begin
         lv = '0;
         if (armed[k]) begin
            case (pk)
               2'd0:    lv = LW'(cnt) + LW'(1);
               2'd1:    lv = LW'(STEPS);
               2'd2:    lv = LW'(STEPS - 1) - LW'(cnt);
               default: lv = '0;
            endcase
         end
      end

      assign lvl[k*LW +: LW] = lv;
      assign hold_vld[k]     = armed[k] && (pk == 2'd1);
   end

endmodule
